// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - request/response and ALU-drive bundle for alu_muldiv_seq
//
// Purpose: groups the start/busy/done handshake, operands, HI/LO results
//   and the shared-ALU drive/capture signals of the multiply/divide sequencer.
// Signals (directions as seen by the sequencer, modport slave):
//   start_i, op_i, a_i[W], b_i[W]            request (op_i: 0 = MULTU, 1 = DIVU)
//   busy_o, done_o, hi_o[W], lo_o[W], div_zero_o   status and results
//   alu_a_o[W], alu_b_o[W], alu_operacion_o[3], alu_invert_o, alu_cin_o   ALU drive
//   alu_result_i[W], alu_cout_i               ALU capture
// Modport master is the environment: requester plus the external ALU.

interface alu_muldiv_seq_if #(
  parameter int W = 32
);
  logic         start_i;
  logic         op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         div_zero_o;
  logic [W-1:0] alu_a_o;
  logic [W-1:0] alu_b_o;
  logic [2:0]   alu_operacion_o;
  logic         alu_invert_o;
  logic         alu_cin_o;
  logic [W-1:0] alu_result_i;
  logic         alu_cout_i;

  modport slave (
    input  start_i, op_i, a_i, b_i, alu_result_i, alu_cout_i,
    output busy_o, done_o, hi_o, lo_o, div_zero_o,
           alu_a_o, alu_b_o, alu_operacion_o, alu_invert_o, alu_cin_o
  );

  modport master (
    output start_i, op_i, a_i, b_i, alu_result_i, alu_cout_i,
    input  busy_o, done_o, hi_o, lo_o, div_zero_o,
           alu_a_o, alu_b_o, alu_operacion_o, alu_invert_o, alu_cin_o
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - multi-cycle MULTU/DIVU sequencer driving a shared external ALU
//
// Purpose: shift-add unsigned multiply and restoring unsigned divide, one
//   iteration per cycle, W iterations per operation. All addition is done by
//   the external ALU; this block only steers its inputs and captures results.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     alu_muldiv_seq_if.slave (handshake, operands, results, ALU drive)

module alu_muldiv_seq #(
  parameter int W  = 32,
  parameter int CW = $clog2(W)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  alu_muldiv_seq_if.slave      bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b000;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          op_q;      // 0 = MULTU, 1 = DIVU
  logic [W-1:0]  hi_q;
  logic [W-1:0]  lo_q;
  logic [W-1:0]  d_q;       // multiplicand (MULTU) or divisor (DIVU)
  logic          div_zero_q;

  // Divide step: remainder shifted left by one with the next dividend bit;
  // t is the bit shifted out of the W-bit remainder register.
  logic [W-1:0]  rem_shift;
  logic          rem_t;

  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [2:0]    alu_op;
  logic          alu_inv;
  logic          alu_cin;

  assign rem_shift = {hi_q[W-2:0], lo_q[W-1]};
  assign rem_t     = hi_q[W-1];

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = OP_AND;
    alu_inv = 1'b0;
    alu_cin = 1'b0;
    if (state == S_RUN) begin
      alu_op = OP_ADD;
      if (!op_q) begin
        alu_a = hi_q;
        alu_b = lo_q[0] ? d_q : '0;
      end else begin
        // R' - D computed as R' + ~D + 1; carry-out means R' >= D.
        alu_a   = rem_shift;
        alu_b   = d_q;
        alu_inv = 1'b1;
        alu_cin = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      count      <= '0;
      op_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      d_q        <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            op_q       <= bus.op_i;
            div_zero_q <= 1'b0;
            count      <= '0;
            if (!bus.op_i) begin
              d_q   <= bus.a_i;
              hi_q  <= '0;
              lo_q  <= bus.b_i;
              state <= S_RUN;
            end else if (bus.b_i != '0) begin
              d_q   <= bus.b_i;
              hi_q  <= '0;
              lo_q  <= bus.a_i;
              state <= S_RUN;
            end else begin
              // Divide by zero: fixed result, skip RUN entirely.
              d_q        <= bus.b_i;
              hi_q       <= bus.a_i;
              lo_q       <= '1;
              div_zero_q <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_RUN: begin
          count <= count + CW'(1);
          if (!op_q) begin
            // Partial product with its carry shifts right into HI:LO.
            {hi_q, lo_q} <= {bus.alu_cout_i, bus.alu_result_i, lo_q[W-1:1]};
          end else if (rem_t | bus.alu_cout_i) begin
            hi_q <= bus.alu_result_i;
            lo_q <= {lo_q[W-2:0], 1'b1};
          end else begin
            hi_q <= rem_shift;
            lo_q <= {lo_q[W-2:0], 1'b0};
          end
          if (count == CW'(W - 1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o          = (state == S_RUN);
  assign bus.done_o          = (state == S_DONE);
  assign bus.hi_o            = hi_q;
  assign bus.lo_o            = lo_q;
  assign bus.div_zero_o      = div_zero_q;
  assign bus.alu_a_o         = alu_a;
  assign bus.alu_b_o         = alu_b;
  assign bus.alu_operacion_o = alu_op;
  assign bus.alu_invert_o    = alu_inv;
  assign bus.alu_cin_o       = alu_cin;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - directed table-driven bench for alu_muldiv_seq with an ALU model

module tb_alu_muldiv_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_muldiv_seq_if #(.W(32)) bus ();

  alu_muldiv_seq #(.W(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: add/sub with optional B inversion and carry-in, else AND.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, bus.alu_a_o}
            + {1'b0, (bus.alu_invert_o ? ~bus.alu_b_o : bus.alu_b_o)}
            + {32'd0, bus.alu_cin_o};
    if (bus.alu_operacion_o == 3'b010) begin
      bus.alu_result_i = alu_sum[31:0];
      bus.alu_cout_i   = alu_sum[32];
    end else begin
      bus.alu_result_i = bus.alu_a_o & bus.alu_b_o;
      bus.alu_cout_i   = 1'b0;
    end
  end

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge in IDLE. Returns at the negedge where done_o is seen;
  // lat counts cycles after the accepting edge (0 = cycle right after it).
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n, output logic to);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    @(negedge clk);
    bus.start_i = 1'b0;
    lat    = 0;
    busy_n = 0;
    to     = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (bus.busy_o) busy_n++;
      if (bus.done_o) begin
        lat = k;
        to  = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output logic to);
    to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (bus.done_o) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int   lat;
    int   busy_n;
    logic to;
    int   exp_lat;
    int   saw_done;

    checks = 0;
    errors = 0;
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.op_i    = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;

    vecs[0] = '{op: 1'b0, a: 32'd7,        b: 32'd6,        hi: 32'd0,        lo: 32'd42,       dz: 1'b0};
    vecs[1] = '{op: 1'b0, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hi: 32'hFFFFFFFE, lo: 32'h00000001, dz: 1'b0};
    vecs[2] = '{op: 1'b0, a: 32'h00010000, b: 32'h00010000, hi: 32'd1,        lo: 32'd0,        dz: 1'b0};
    vecs[3] = '{op: 1'b0, a: 32'hFFFFFFFF, b: 32'd2,        hi: 32'd1,        lo: 32'hFFFFFFFE, dz: 1'b0};
    vecs[4] = '{op: 1'b1, a: 32'd100,      b: 32'd7,        hi: 32'd2,        lo: 32'd14,       dz: 1'b0};
    vecs[5] = '{op: 1'b1, a: 32'hFFFFFFFF, b: 32'h80000001, hi: 32'h7FFFFFFE, lo: 32'd1,        dz: 1'b0};
    vecs[6] = '{op: 1'b1, a: 32'd5,        b: 32'd10,       hi: 32'd5,        lo: 32'd0,        dz: 1'b0};
    vecs[7] = '{op: 1'b1, a: 32'h00001234, b: 32'd0,        hi: 32'h00001234, lo: 32'hFFFFFFFF, dz: 1'b1};
    vecs[8] = '{op: 1'b0, a: 32'd0,        b: 32'd5,        hi: 32'd0,        lo: 32'd0,        dz: 1'b0};
    vecs[9] = '{op: 1'b1, a: 32'hFFFFFFFF, b: 32'd1,        hi: 32'd0,        lo: 32'hFFFFFFFF, dz: 1'b0};

    // Reset state
    #12;
    chk("rst_busy", {63'd0, bus.busy_o}, 64'd0);
    chk("rst_done", {63'd0, bus.done_o}, 64'd0);
    chk("rst_hi", {32'd0, bus.hi_o}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo_o}, 64'd0);
    chk("rst_dz", {63'd0, bus.div_zero_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle ALU drive
    chk("idle_op", {61'd0, bus.alu_operacion_o}, 64'd0);
    chk("idle_ab", {bus.alu_a_o, bus.alu_b_o}, 64'd0);
    chk("idle_inv_cin", {62'd0, bus.alu_invert_o, bus.alu_cin_o}, 64'd0);

    // Table-driven operations
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_n, to);
      exp_lat = (vecs[i].op && vecs[i].b == 32'd0) ? 0 : 32;
      chk($sformatf("v%0d_timeout", i), {63'd0, to}, 64'd0);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(exp_lat));
      chk($sformatf("v%0d_busy_cycles", i), 64'(busy_n), 64'(exp_lat));
      chk($sformatf("v%0d_hi", i), {32'd0, bus.hi_o}, {32'd0, vecs[i].hi});
      chk($sformatf("v%0d_lo", i), {32'd0, bus.lo_o}, {32'd0, vecs[i].lo});
      chk($sformatf("v%0d_dz", i), {63'd0, bus.div_zero_o}, {63'd0, vecs[i].dz});
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {63'd0, bus.done_o}, 64'd0);
      chk($sformatf("v%0d_hold", i), {bus.hi_o, bus.lo_o}, {vecs[i].hi, vecs[i].lo});
    end

    // MULTU ALU drive: D=5, multiplier 2 (lo[0]=0 first, then 1)
    bus.start_i = 1'b1; bus.op_i = 1'b0; bus.a_i = 32'd5; bus.b_i = 32'd2;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("mul_c0_op", {61'd0, bus.alu_operacion_o}, 64'd2);
    chk("mul_c0_inv_cin", {62'd0, bus.alu_invert_o, bus.alu_cin_o}, 64'd0);
    chk("mul_c0_b_zero", {32'd0, bus.alu_b_o}, 64'd0);
    @(negedge clk);
    chk("mul_c1_b_d", {32'd0, bus.alu_b_o}, 64'd5);
    chk("mul_c1_op", {61'd0, bus.alu_operacion_o}, 64'd2);
    wait_done(to);
    chk("mul_port_timeout", {63'd0, to}, 64'd0);
    chk("mul_port_result", {bus.hi_o, bus.lo_o}, 64'd10);
    @(negedge clk);

    // DIVU with an ignored start at RUN cycle 5; DIVU port drive at cycle 0
    bus.start_i = 1'b1; bus.op_i = 1'b1; bus.a_i = 32'd100; bus.b_i = 32'd7;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("div_c0_inv_cin", {62'd0, bus.alu_invert_o, bus.alu_cin_o}, 64'd3);
    chk("div_c0_b_d", {32'd0, bus.alu_b_o}, 64'd7);
    chk("div_c0_op", {61'd0, bus.alu_operacion_o}, 64'd2);
    repeat (5) @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 1'b0; bus.a_i = 32'd3; bus.b_i = 32'd3;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_done(to);
    chk("ign_timeout", {63'd0, to}, 64'd0);
    chk("ign_result", {bus.hi_o, bus.lo_o}, {32'd2, 32'd14});
    @(negedge clk);
    chk("ign_back_idle", {62'd0, bus.busy_o, bus.done_o}, 64'd0);

    // Reset at RUN cycle 10 aborts without done
    bus.start_i = 1'b1; bus.op_i = 1'b0; bus.a_i = 32'd7; bus.b_i = 32'd6;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", {63'd0, bus.busy_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {61'd0, bus.busy_o, bus.done_o, bus.div_zero_o}, 64'd0);
    chk("mid_rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    chk("mid_rst_alu", {bus.alu_a_o, bus.alu_b_o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) saw_done++;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);

    run_op(1'b0, 32'h0000FFFF, 32'h0000FFFF, lat, busy_n, to);
    chk("post_rst_timeout", {63'd0, to}, 64'd0);
    chk("post_rst_lat", 64'(lat), 64'd32);
    chk("post_rst_result", {bus.hi_o, bus.lo_o}, {32'd0, 32'hFFFE0001});
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
